trap_ctrl: RTL
==============

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/CSR data width.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports exc_valid/exc_pc/exc_cause/exc_tval  input  1/XLEN/XLEN/XLEN  synchronous exception request, faulting PC, cause code, trap value.
REQ-005 SHALL have ports irq_ext/irq_sw/irq_tmr  input  1 each  level interrupt pending lines.
REQ-006 SHALL have ports mstatus_mie/mie_meie/mie_msie/mie_mtie  input  1 each  global and per-source interrupt enables.
REQ-007 SHALL have ports mret_valid  input  1  mret request; next_pc  input  XLEN  PC of next unexecuted instruction.
REQ-008 SHALL have ports ins_csr_req/ins_csr_we/ins_csr_idx/ins_csr_wdata  input  1/1/12/XLEN  pipeline CSR access; ins_csr_gnt  output  1  grant.
REQ-009 SHALL have ports csr_rd_en/csr_wb_en/csr_idx/csr_wdata  output  1/1/12/XLEN  CSR file port; csr_rdata  input  XLEN  combinational read data.
REQ-010 SHALL have outputs trap_ack, mret_ack, trap_busy, redirect_valid (1 each) and redirect_pc (XLEN).

Function
REQ-011 SHALL implement states IDLE, W_EPC, W_CAUSE, W_TVAL, R_STATUS, W_STATUS, R_TVEC, M_R_STATUS, M_W_STATUS, M_R_EPC, REDIRECT.
REQ-012 SHALL sample events only in IDLE; priority exception > interrupt > mret; lower-priority events ignored that cycle.
REQ-013 SHALL take an interrupt only when mstatus_mie=1 and enabled-and-pending; source priority ext(code 11) > sw(3) > tmr(7).
REQ-014 SHALL on accepted trap capture epc (exc_pc or next_pc), cause (exc_cause, or {1'b1, code} for interrupts), tval (exc_tval, or 0 for interrupts), pulse trap_ack 1 cycle, go to W_EPC.
REQ-015 SHALL sequence one CSR op per cycle: W_EPC writes 0x341=epc; W_CAUSE 0x342=cause; W_TVAL 0x343=tval; R_STATUS reads 0x300 into status reg; W_STATUS writes status with bit7(MPIE)=old bit3, bit3(MIE)=0, bits12:11(MPP)=2'b11; R_TVEC reads 0x305 into tvec reg; then REDIRECT.
REQ-016 SHALL on accepted mret pulse mret_ack, then M_R_STATUS reads 0x300; M_W_STATUS writes bit3=old bit7, bit7=1, bits12:11=2'b11; M_R_EPC reads 0x341 into target; then REDIRECT.
REQ-017 SHALL compute trap target: tvec[1:0]==2'b01 and cause[XLEN-1]=1 -> {tvec[XLEN-1:2],2'b00} + 4*cause[XLEN-2:0] (mod 2^XLEN); otherwise {tvec[XLEN-1:2],2'b00}.
REQ-018 SHALL in REDIRECT assert redirect_valid for exactly 1 cycle with redirect_pc=target, then return to IDLE.
REQ-019 SHALL assert trap_busy in every non-IDLE state.
REQ-020 SHALL grant pipeline CSR access (ins_csr_gnt=1, port driven from ins_csr_* combinationally) only in IDLE with no event accepted that cycle; otherwise ins_csr_gnt=0 and port driven by sequencer.
REQ-021 SHALL assert csr_rd_en/csr_wb_en only in the state performing that op; both 0 in IDLE without grant and in REDIRECT.
REQ-022 SHALL trap latency be 7 cycles (accept cycle 0 -> redirect_valid cycle 7) and mret latency 4 cycles.
REQ-023 SHALL treat requesters holding exc_valid/mret_valid while busy as pending, accepted on the next IDLE cycle.

Reset
REQ-024 SHALL on rst asynchronously enter IDLE and clear epc/cause/tval/status/tvec/target registers to 0.
REQ-025 SHALL drive all outputs 0 during reset; reset mid-sequence SHALL abort with no further CSR writes.

Verification
REQ-026 Exception exc_pc=0x80, exc_cause=2, exc_tval=0xDEAD, mtvec=0x1000, mstatus=0x8 -> writes 0x341=0x80, 0x342=2, 0x343=0xDEAD, 0x300=0x1880; redirect_pc=0x1000 at cycle 7.
REQ-027 irq_tmr=1, mie_mtie=1, mstatus_mie=1, mtvec=0x1001, next_pc=0x200 -> cause=0x80000007, epc=0x200, redirect_pc=0x101C.
REQ-028 irq_tmr=1, mstatus_mie=0 -> no trap_ack; ins_csr_req granted normally.
REQ-029 exc_valid, irq_ext, mret_valid same cycle -> exception taken; after return to IDLE, interrupt taken before mret.
REQ-030 mret with mstatus=0x1880, mepc=0x84 -> writes 0x300=0x1888; redirect_pc=0x84 at cycle 4.
REQ-031 rst asserted in W_CAUSE -> immediate IDLE, all outputs 0, no write to 0x343.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret sequencer: serialises the CSR updates of a trap entry or
// an mret onto a single CSR port, then issues one redirect to the new PC.
module trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_tmr,
  input  logic            mstatus_mie,
  input  logic            mie_meie,
  input  logic            mie_msie,
  input  logic            mie_mtie,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] next_pc,
  input  logic            ins_csr_req,
  input  logic            ins_csr_we,
  input  logic [11:0]     ins_csr_idx,
  input  logic [XLEN-1:0] ins_csr_wdata,
  output logic            ins_csr_gnt,
  output logic            csr_rd_en,
  output logic            csr_wb_en,
  output logic [11:0]     csr_idx,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            trap_ack,
  output logic            mret_ack,
  output logic            trap_busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);
  typedef enum logic [3:0] {
    IDLE, W_EPC, W_CAUSE, W_TVAL, R_STATUS, W_STATUS, R_TVEC,
    M_R_STATUS, M_W_STATUS, M_R_EPC, REDIRECT
  } state_t;

  localparam logic [11:0] MSTATUS = 12'h300, MTVEC = 12'h305, MEPC = 12'h341,
                          MCAUSE = 12'h342, MTVAL = 12'h343;

  state_t state, state_nx;
  logic [XLEN-1:0] epc, cause, tval, status, tvec, target;
  logic is_mret;
  logic irq_take, take_exc, take_irq, take_mret;
  logic [XLEN-2:0] irq_code;
  logic [XLEN-1:0] tvec_base, vec_off, trap_tgt, trap_status, mret_status;

  // Interrupt source priority: external > software > timer.
  always_comb begin
    irq_take = mstatus_mie & ((irq_ext & mie_meie) | (irq_sw & mie_msie) | (irq_tmr & mie_mtie));
    if (irq_ext & mie_meie)     irq_code = (XLEN-1)'(11);
    else if (irq_sw & mie_msie) irq_code = (XLEN-1)'(3);
    else                        irq_code = (XLEN-1)'(7);
  end

  assign take_exc  = (state == IDLE) & exc_valid;
  assign take_irq  = (state == IDLE) & ~exc_valid & irq_take;
  assign take_mret = (state == IDLE) & ~exc_valid & ~irq_take & mret_valid;

  // Vectored mode only applies to interrupts; exceptions always go to the base.
  assign tvec_base = {tvec[XLEN-1:2], 2'b00};
  assign vec_off   = {1'b0, cause[XLEN-2:0]} << 2;
  assign trap_tgt  = (tvec[1:0] == 2'b01 && cause[XLEN-1]) ? tvec_base + vec_off : tvec_base;

  always_comb begin
    trap_status        = status;
    trap_status[7]     = status[3];
    trap_status[3]     = 1'b0;
    trap_status[12:11] = 2'b11;
    mret_status        = status;
    mret_status[3]     = status[7];
    mret_status[7]     = 1'b1;
    mret_status[12:11] = 2'b11;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (take_exc | take_irq) state_nx = W_EPC;
                  else if (take_mret)      state_nx = M_R_STATUS;
      W_EPC:      state_nx = W_CAUSE;
      W_CAUSE:    state_nx = W_TVAL;
      W_TVAL:     state_nx = R_STATUS;
      R_STATUS:   state_nx = W_STATUS;
      W_STATUS:   state_nx = R_TVEC;
      R_TVEC:     state_nx = REDIRECT;
      M_R_STATUS: state_nx = M_W_STATUS;
      M_W_STATUS: state_nx = M_R_EPC;
      M_R_EPC:    state_nx = REDIRECT;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc <= '0; cause <= '0; tval <= '0; status <= '0; tvec <= '0; target <= '0;
      is_mret <= 1'b0;
    end else begin
      if (take_exc) begin
        epc <= exc_pc; cause <= exc_cause; tval <= exc_tval; is_mret <= 1'b0;
      end else if (take_irq) begin
        epc <= next_pc; cause <= {1'b1, irq_code}; tval <= '0; is_mret <= 1'b0;
      end else if (take_mret) begin
        is_mret <= 1'b1;
      end
      if (state == R_STATUS || state == M_R_STATUS) status <= csr_rdata;
      if (state == R_TVEC)  tvec   <= csr_rdata;
      if (state == M_R_EPC) target <= csr_rdata;
    end
  end

  // Reset gates every output so a held request cannot leak an ack or CSR op.
  always_comb begin
    ins_csr_gnt = 1'b0; csr_rd_en = 1'b0; csr_wb_en = 1'b0;
    csr_idx = '0; csr_wdata = '0;
    trap_ack = 1'b0; mret_ack = 1'b0; trap_busy = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    if (!rst) begin
      trap_busy = (state != IDLE);
      case (state)
        IDLE: begin
          trap_ack = take_exc | take_irq;
          mret_ack = take_mret;
          if (!(take_exc | take_irq | take_mret) && ins_csr_req) begin
            ins_csr_gnt = 1'b1;
            csr_rd_en   = ~ins_csr_we;
            csr_wb_en   = ins_csr_we;
            csr_idx     = ins_csr_idx;
            csr_wdata   = ins_csr_wdata;
          end
        end
        W_EPC:      begin csr_wb_en = 1'b1; csr_idx = MEPC;    csr_wdata = epc;         end
        W_CAUSE:    begin csr_wb_en = 1'b1; csr_idx = MCAUSE;  csr_wdata = cause;       end
        W_TVAL:     begin csr_wb_en = 1'b1; csr_idx = MTVAL;   csr_wdata = tval;        end
        R_STATUS:   begin csr_rd_en = 1'b1; csr_idx = MSTATUS;                          end
        W_STATUS:   begin csr_wb_en = 1'b1; csr_idx = MSTATUS; csr_wdata = trap_status; end
        R_TVEC:     begin csr_rd_en = 1'b1; csr_idx = MTVEC;                            end
        M_R_STATUS: begin csr_rd_en = 1'b1; csr_idx = MSTATUS;                          end
        M_W_STATUS: begin csr_wb_en = 1'b1; csr_idx = MSTATUS; csr_wdata = mret_status; end
        M_R_EPC:    begin csr_rd_en = 1'b1; csr_idx = MEPC;                             end
        REDIRECT: begin
          redirect_valid = 1'b1;
          redirect_pc    = is_mret ? target : trap_tgt;
        end
        default: ;
      endcase
    end
  end
endmodule
